// File: rtl/mips_pkg.sv
// Shared encodings for the 16-bit simplified MIPS core: opcodes, ALU controls,
// multi-cycle controller states and datapath mux selects.
package mips_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  localparam logic [15:0] HALT_INSTR = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB_R   = 3'd4,
    ST_WB_M   = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_BNE;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for the shared memory port: counts consecutive stalled request
// cycles and flags the cycle in which the count would reach WAIT_LIMIT.
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic busy,
  output logic expired
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = busy ? count_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= 8'd0;
    else       count_q <= count_d;
  end

  // Only asserted while still stalled, so a ready in the limit cycle wins.
  assign expired = busy && (count_d == 8'(WAIT_LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM: steps each instruction through fetch, decode,
// execute, memory and writeback over one shared, ready-handshaked memory port.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  state_e     state_q, state_d;
  logic [3:0] opcode;
  logic       mem_access;
  logic       wait_expired;
  logic       taken;

  assign opcode     = instruction[15:12];
  assign mem_access = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign state      = state_q;

  // mem_access is decoded outside the main block so the watchdog feedback
  // into next-state logic does not form a combinational loop through mem_req.
  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .busy    (mem_access && !mem_ready),
    .expired (wait_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = mem_access;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RD2;
    alu_control = ALU_AND;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = (state_q == ST_HALT);
    fault       = (state_q == ST_FAULT);
    taken       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        alu_src_b   = SRCB_TWO;
        alu_control = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        alu_src_b   = SRCB_IMM_SH;
        alu_control = ALU_ADD;
        if (instruction == HALT_INSTR) state_d = ST_HALT;
        else if (!is_legal_op(opcode)) state_d = ST_FAULT;
        else                           state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // Every execute form takes its first operand from RD1.
        alu_src_a = 1'b1;
        state_d   = ST_WB_R;
        case (opcode)
          OP_ADD:  alu_control = ALU_ADD;
          OP_SUB:  alu_control = ALU_SUB;
          OP_AND:  alu_control = ALU_AND;
          OP_OR:   alu_control = ALU_OR;
          OP_SLT:  alu_control = ALU_SLT;
          OP_ADDI: begin
            alu_src_b   = SRCB_IMM;
            alu_control = ALU_ADD;
          end
          OP_LW, OP_SW: begin
            alu_src_b   = SRCB_IMM;
            alu_control = ALU_ADD;
            state_d     = ST_MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_control = ALU_SUB;
            taken       = (opcode == OP_BEQ) ? zero : !zero;
            pc_write    = taken;
            pc_src      = taken ? PC_SRC_ALUOUT : PC_SRC_ALU;
            state_d     = ST_FETCH;
          end
          default: state_d = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        iord   = 1'b1;
        mem_we = (opcode == OP_SW);
        if (mem_ready)         state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB_M;
        else if (wait_expired) state_d = ST_FAULT;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_WB_M: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction cycle plans are
// generated from the instruction semantics and checked cycle by cycle.
module tb_multicycle_control;

  localparam int LIMIT = 4;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WBR    = 3'd4;
  localparam logic [2:0] S_WBM    = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_control;
  logic        reg_write, mem_to_reg, halted, fault;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] exp_q[$];
  logic       rdy_q[$];

  multicycle_control #(.WAIT_LIMIT(LIMIT)) dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .halted      (halted),
    .fault       (fault),
    .state       (state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] dut_vec();
    return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
            alu_src_b, alu_control, reg_write, mem_to_reg, halted, fault};
  endfunction

  // Expected control word for one cycle, straight from the state/opcode table.
  function automatic logic [16:0] model_out(input logic [2:0] st, input logic [15:0] ins,
                                            input logic z, input logic rdy);
    logic mreq = 0, we = 0, io = 0, irw = 0, pcw = 0, pcs = 0, srca = 0;
    logic [1:0] srcb = 0;
    logic [3:0] alu = 0;
    logic rw = 0, m2r = 0, h = 0, f = 0, tk = 0;
    int op = int'(ins[15:12]);
    case (st)
      S_FETCH: begin
        mreq = 1; srcb = 2'b01; alu = 4'b0010;
        if (rdy) begin irw = 1; pcw = 1; end
      end
      S_DECODE: begin srcb = 2'b11; alu = 4'b0010; end
      S_EXEC: begin
        srca = 1;
        case (op)
          0: alu = 4'b0010;
          1: alu = 4'b0110;
          2: alu = 4'b0000;
          3: alu = 4'b0001;
          4: alu = 4'b0111;
          5, 6, 7: begin srcb = 2'b10; alu = 4'b0010; end
          8, 9: begin
            alu = 4'b0110;
            tk  = (op == 8) ? z : !z;
            pcw = tk; pcs = tk;
          end
          default: ;
        endcase
      end
      S_MEM:  begin mreq = 1; io = 1; we = (op == 7); end
      S_WBR:  rw = 1;
      S_WBM:  begin rw = 1; m2r = 1; end
      S_HALT: h = 1;
      default: f = 1;
    endcase
    return {mreq, we, io, irw, pcw, pcs, srca, srcb, alu, rw, m2r, h, f};
  endfunction

  // ---------------- plan building (reference model) ----------------
  task automatic push(input logic [2:0] st, input logic rdy);
    exp_q.push_back(st);
    rdy_q.push_back(rdy);
  endtask

  // A memory access stalls for `waits` cycles; the watchdog gives up after LIMIT.
  task automatic push_access(input logic [2:0] st, input int waits, output bit faulted);
    faulted = 0;
    if (waits >= LIMIT) begin
      repeat (LIMIT) push(st, 1'b0);
      push(S_FAULT, 1'($urandom_range(0, 1)));
      faulted = 1;
    end else begin
      repeat (waits) push(st, 1'b0);
      push(st, 1'b1);
    end
  endtask

  task automatic build_plan(input logic [15:0] ins, input int fw, input int mw);
    int op = int'(ins[15:12]);
    bit flt;
    push_access(S_FETCH, fw, flt);
    if (flt) return;
    push(S_DECODE, 1'($urandom_range(0, 1)));
    if (ins == 16'hFFFF) begin push(S_HALT, 1'($urandom_range(0, 1))); return; end
    if (op > 9) begin push(S_FAULT, 1'($urandom_range(0, 1))); return; end
    push(S_EXEC, 1'($urandom_range(0, 1)));
    if (op <= 5) push(S_WBR, 1'($urandom_range(0, 1)));
    else if (op == 6 || op == 7) begin
      push_access(S_MEM, mw, flt);
      if (!flt && op == 6) push(S_WBM, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic hold(input logic [2:0] st, input int n);
    repeat (n) push(st, 1'($urandom_range(0, 1)));
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clock);
    #1;
    check("reset.state", 32'(state), 32'(S_FETCH));
    check("reset.outputs", 32'(dut_vec()), 32'(model_out(S_FETCH, instruction, zero, 1'b0)));
  endtask

  task automatic run_plan(input string name, input logic [15:0] ins, input logic z,
                          input int max_steps);
    int step = 0;
    logic [2:0] st;
    logic rdy;
    while (exp_q.size() > 0 && step < max_steps) begin
      st  = exp_q.pop_front();
      rdy = rdy_q.pop_front();
      @(negedge clock);
      reset       = 1'b0;
      instruction = ins;
      zero        = z;
      mem_ready   = rdy;
      #1;
      check($sformatf("%s.state[%0d]", name, step), 32'(state), 32'(st));
      check($sformatf("%s.outputs[%0d]", name, step), 32'(dut_vec()),
            32'(model_out(st, ins, z, rdy)));
      step++;
    end
  endtask

  task automatic run_instr(input string name, input logic [15:0] ins, input logic z,
                           input int fw, input int mw);
    build_plan(ins, fw, mw);
    run_plan(name, ins, z, 1000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ins;
    int op;
    reset       = 1'b1;
    instruction = 16'h0000;
    zero        = 1'b0;
    mem_ready   = 1'b0;
    do_reset();

    run_instr("add", 16'h0180, 1'b0, 0, 0);
    run_instr("lw", 16'h6104, 1'b0, 0, 2);
    run_instr("sw", 16'h7108, 1'b0, 0, 2);
    run_instr("beq_taken", 16'h8006, 1'b1, 0, 0);
    run_instr("beq_not", 16'h8006, 1'b0, 0, 0);
    run_instr("bne", 16'h9006, 1'b0, 0, 0);
    run_instr("fetch_ready_at_limit", 16'h1234, 1'b0, LIMIT - 1, 0);
    run_instr("mem_ready_at_limit", 16'h6234, 1'b0, 0, LIMIT - 1);

    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 9);
      ins = {op[3:0], 12'($urandom)};
      run_instr("rand", ins, 1'($urandom_range(0, 1)),
                $urandom_range(0, LIMIT - 1), $urandom_range(0, LIMIT - 1));
    end

    build_plan(16'hFFFF, 1, 0);
    hold(S_HALT, 20);
    run_plan("halt", 16'hFFFF, 1'b0, 1000);

    do_reset();
    build_plan(16'h0180, LIMIT, 0);
    hold(S_FAULT, 3);
    run_plan("fetch_timeout", 16'h0180, 1'b0, 1000);

    do_reset();
    build_plan(16'h7108, 0, LIMIT + 2);
    hold(S_FAULT, 2);
    run_plan("mem_timeout", 16'h7108, 1'b0, 1000);

    do_reset();
    build_plan(16'hB123, 0, 0);
    hold(S_FAULT, 3);
    run_plan("illegal", 16'hB123, 1'b0, 1000);

    // Abandon a SW in its first MEM cycle with an asynchronous reset.
    do_reset();
    build_plan(16'h7108, 0, 3);
    run_plan("sw_abort", 16'h7108, 1'b0, 4);
    exp_q.delete();
    rdy_q.delete();
    #1 reset = 1'b1;
    #1;
    check("async_reset.state", 32'(state), 32'(S_FETCH));
    check("async_reset.mem_we", 32'(mem_we), 32'(0));
    check("async_reset.mem_req", 32'(mem_req), 32'(1));
    run_instr("after_reset", 16'h5103, 1'b0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
